// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default width for the execute-stage ALU.
// Optional single-cycle shifter is enabled by defining ALU_FAST_SHIFT_EN.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: loads operand and count on start, shifts until the
// count runs out. done is high in the cycle whose edge produces the final value.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int W  = XLEN_DEFAULT,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          start,
    input  logic          dir_right,
    input  logic          arith,
    input  logic [W-1:0]  a_in,
    input  logic [SW-1:0] shamt,
    output logic          done,
    output logic [W-1:0]  acc_next
);

    logic [W-1:0]  acc_q, acc_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          arith_q, arith_d;

    // acc_next is the value acc takes at the coming edge while iterating.
    always_comb begin
        if (dir_q) begin
            acc_next = {arith_q & acc_q[W-1], acc_q[W-1:1]};
        end else begin
            acc_next = {acc_q[W-2:0], 1'b0};
        end
    end

    assign done = (cnt_q == SW'(1));

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        if (flush) begin
            cnt_d = '0;
        end else if (start) begin
            acc_d   = a_in;
            cnt_d   = shamt;
            dir_d   = dir_right;
            arith_d = arith;
        end else if (cnt_q != '0) begin
            acc_d = acc_next;
            cnt_d = cnt_q - SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a registered result.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; default shifts 1 bit/cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy,
    output logic [1:0]      state_dbg
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] op_result;
    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            launch_shift;
    logic            shift_start;
    logic            shift_done;
    logic [XLEN-1:0] shift_next;

    assign shamt = op_b[SHW-1:0];

    // Handshake: a transfer happens on an edge where valid & ready are both high.
    // in_ready may depend combinationally on out_ready (back-to-back from HOLD).
    // out_valid stays high with a stable result until the consumer's out_ready.
    assign in_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready));
    assign accept   = in_valid & in_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign launch_shift = 1'b0;
    assign shift_done   = 1'b0;
    assign shift_next   = '0;
`else
    assign launch_shift = is_shift_op(alu_sel) && (shamt != '0);

    alu_shift_iter #(
        .W  (XLEN),
        .SW (SHW)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (shift_start),
        .dir_right (alu_sel != ALU_SLL),
        .arith     (alu_sel == ALU_SRA),
        .a_in      (op_a),
        .shamt     (shamt),
        .done      (shift_done),
        .acc_next  (shift_next)
    );
`endif

    always_comb begin
        op_result = '0;
        case (alu_sel)
            ALU_ADD:  op_result = op_a + op_b;
            ALU_SUB:  op_result = op_a - op_b;
            ALU_XOR:  op_result = op_a ^ op_b;
            ALU_OR:   op_result = op_a | op_b;
            ALU_AND:  op_result = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  op_result = op_a << shamt;
            ALU_SRL:  op_result = op_a >> shamt;
            ALU_SRA:  op_result = $unsigned($signed(op_a) >>> shamt);
`else
            // Only reached with shamt == 0; non-zero shifts go through the iterator.
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  op_result = op_a;
`endif
            ALU_SLT:  op_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: op_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:  op_result = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        shift_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (launch_shift) begin
                        state_d     = ST_SHIFT;
                        shift_start = 1'b1;
                    end else begin
                        state_d  = ST_HOLD;
                        result_d = op_result;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d  = ST_HOLD;
                    result_d = shift_next;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    if (launch_shift) begin
                        state_d     = ST_SHIFT;
                        shift_start = 1'b1;
                    end else begin
                        result_d = op_result;
                    end
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Kill wins over everything; the last result stays visible on the bus.
        if (flush) begin
            state_d     = ST_IDLE;
            result_d    = result_q;
            shift_start = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (default iterative-shift build).
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_sel  = sel;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        alu_sel  = 4'd0;
        op_a     = '0;
        op_b     = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        idle_in();
        step();
        step();
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp %h", result, 32'h0); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags got valid %b busy %b exp 0 0", out_valid, busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        step();
        idle_in();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got %h exp %h", result, 32'h8000_0000); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", zero); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_release got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(ALU_SUB, 32'd5, 32'd5);
        step();
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL sub_eq got %h zero %b exp 0 zero 1", result, zero); end
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        step();
        checks++; if (result !== 32'h1 || out_valid !== 1'b1) begin errors++; $display("FAIL slt got %h valid %b exp 1 valid 1", result, out_valid); end
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'h1);
        step();
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL sltu got %h exp 0", result); end
        drive(ALU_XOR, 32'hF0F0_F0F0, 32'h0F0F_00FF);
        step();
        checks++; if (result !== 32'hFFFF_F00F) begin errors++; $display("FAIL xor got %h exp %h", result, 32'hFFFF_F00F); end
        idle_in();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release got %b exp 0", out_valid); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        drive(ALU_ADD, 32'h10, 32'h20);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h30 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got valid %b result %h ready %b exp 1 %h 0", i, out_valid, result, in_ready, 32'h30);
            end
            step();
        end
        out_ready = 1'b1;
        drive(ALU_OR, 32'h12, 32'h21);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_b2b_ready got %b exp 1", in_ready); end
        step();
        idle_in();
        checks++; if (out_valid !== 1'b1 || result !== 32'h33) begin errors++; $display("FAIL hold_b2b got valid %b result %h exp 1 %h", out_valid, result, 32'h33); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", out_valid); end
    endtask

    task automatic test_shift();
        out_ready = 1'b1;
        drive(ALU_SRA, 32'h8000_0000, 32'h24);
        step();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL sra_wait cyc %0d got valid %b ready %b busy %b exp 0 0 1", i, out_valid, in_ready, busy);
            end
            step();
        end
        checks++; if (out_valid !== 1'b1 || result !== 32'hF800_0000) begin errors++; $display("FAIL sra got valid %b result %h exp 1 %h", out_valid, result, 32'hF800_0000); end
        step();
        drive(ALU_SLL, 32'h3, 32'hFFFF_FFE2);
        step();
        idle_in();
        step();
        step();
        checks++; if (out_valid !== 1'b1 || result !== 32'hC) begin errors++; $display("FAIL sll got valid %b result %h exp 1 %h", out_valid, result, 32'hC); end
        step();
        drive(ALU_SRL, 32'h8000_0000, 32'h1);
        step();
        idle_in();
        step();
        checks++; if (out_valid !== 1'b1 || result !== 32'h4000_0000) begin errors++; $display("FAIL srl got valid %b result %h exp 1 %h", out_valid, result, 32'h4000_0000); end
        step();
        drive(ALU_SRL, 32'h1234, 32'h20);
        step();
        idle_in();
        checks++; if (out_valid !== 1'b1 || result !== 32'h1234) begin errors++; $display("FAIL srl_shamt0 got valid %b result %h exp 1 %h", out_valid, result, 32'h1234); end
        step();
    endtask

    task automatic test_flush();
        logic seen;
        out_ready = 1'b1;
        drive(ALU_SLL, 32'h1, 32'h14);
        step();
        idle_in();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle got valid %b busy %b exp 0 0", out_valid, busy); end
        checks++; if (result !== 32'h1234) begin errors++; $display("FAIL flush_keep got %h exp %h", result, 32'h1234); end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid got %b exp 0", seen); end
        drive(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
        step();
        idle_in();
        checks++; if (out_valid !== 1'b1 || result !== 32'h0F00_0F00) begin errors++; $display("FAIL flush_next got valid %b result %h exp 1 %h", out_valid, result, 32'h0F00_0F00); end
        step();
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd2, 32'd3);
        step();
        idle_in();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || result !== 32'd5) begin errors++; $display("FAIL flush_hold got valid %b result %h exp 0 %h", out_valid, result, 32'd5); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        out_ready = 1'b1;
        drive(ALU_SRL, 32'hFFFF_FFFF, 32'h10);
        step();
        idle_in();
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL rst_async_result got %h zero %b exp 0 zero 1", result, zero); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async_flags got valid %b busy %b exp 0 0", out_valid, busy); end
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_dropped got %b exp 0", seen); end
        drive(ALU_ADD, 32'd2, 32'd3);
        step();
        checks++; if (result !== 32'd5 || zero !== 1'b0) begin errors++; $display("FAIL post_rst_add got %h zero %b exp %h zero 0", result, zero, 32'd5); end
        drive(4'b1111, 32'd5, 32'd3);
        step();
        idle_in();
        checks++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL illegal got valid %b result %h zero %b exp 1 0 1", out_valid, result, zero); end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_hold();
        test_shift();
        test_flush();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
